exp4_unidade_controle: RTL and testbench

Moore control unit that sequences the exp4 data path: the address counter, the synchronous 16x4 ROM, the 4-bit switch register and the equality comparator. It starts a round on `iniciar`, waits for each `jogada` press, captures the switches, compares them with the current ROM word, and advances the address. The round ends in success after all 16 words match, or in error on the first mismatch. It drives only the data path's strobes and the top-level status/debug outputs.

---
 rtl/exp4_unidade_controle.sv | 140 ++++++++++++++
 tb/tb_exp4_unidade_controle.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/exp4_unidade_controle.sv
// exp4 control unit: Moore FSM driving counter, ROM, switch register and comparator.
// Define UNIDADE_CONTROLE_TIMEOUT_EN to build the per-press timeout (fim_timeout).
module exp4_unidade_controle #(
   parameter int TIMEOUT_CYCLES = 5000
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       iniciar,
   input  logic       jogada,
   input  logic       chavesIgualMemoria,
   input  logic       fimC,
   output logic       zeraC,
   output logic       contaC,
   output logic       zeraR,
   output logic       registraR,
   output logic       pronto,
   output logic       acertou,
   output logic       errou,
   output logic       timeout,
   output logic [3:0] db_estado
);

   localparam logic [3:0] INICIAL     = 4'h0;
   localparam logic [3:0] PREPARACAO  = 4'h1;
   localparam logic [3:0] ESPERA      = 4'h2;
   localparam logic [3:0] REGISTRA    = 4'h4;
   localparam logic [3:0] COMPARACAO  = 4'h5;
   localparam logic [3:0] PROXIMO     = 4'h6;
   localparam logic [3:0] FIM_ACERTO  = 4'hA;
   localparam logic [3:0] FIM_TIMEOUT = 4'hD;
   localparam logic [3:0] FIM_ERRO    = 4'hE;

   if (TIMEOUT_CYCLES < 2) begin : g_param_check
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   logic [3:0] estado;
   logic [3:0] prox;
   logic       iniciar_d;
   logic       jogada_d;
   logic       iniciar_ed;
   logic       jogada_ed;
   logic       expirou;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         iniciar_d <= 1'b0;
         jogada_d  <= 1'b0;
      end else begin
         iniciar_d <= iniciar;
         jogada_d  <= jogada;
      end
   end

   assign iniciar_ed = iniciar & ~iniciar_d;
   assign jogada_ed  = jogada & ~jogada_d;

`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] ULTIMO = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] cnt;

   // Counts idle espera cycles; any other state restarts the window.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (estado != ESPERA) begin
         cnt <= '0;
      end else if (!jogada_ed) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expirou = (cnt == ULTIMO);
   assign timeout = (estado == FIM_TIMEOUT);
`else
   assign expirou = 1'b0;
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         estado <= INICIAL;
      end else begin
         estado <= prox;
      end
   end

   always_comb begin
      prox = INICIAL;
      case (estado)
         INICIAL:
            prox = iniciar_ed ? PREPARACAO : INICIAL;
         PREPARACAO:
            prox = ESPERA;
         ESPERA: begin
            if (jogada_ed) begin
               prox = REGISTRA;
            end else if (expirou) begin
               prox = FIM_TIMEOUT;
            end else begin
               prox = ESPERA;
            end
         end
         REGISTRA:
            prox = COMPARACAO;
         // A mismatch ends the round even on the last word.
         COMPARACAO: begin
            if (!chavesIgualMemoria) begin
               prox = FIM_ERRO;
            end else if (fimC) begin
               prox = FIM_ACERTO;
            end else begin
               prox = PROXIMO;
            end
         end
         PROXIMO:
            prox = ESPERA;
         FIM_ACERTO:
            prox = iniciar_ed ? PREPARACAO : FIM_ACERTO;
         FIM_ERRO:
            prox = iniciar_ed ? PREPARACAO : FIM_ERRO;
         FIM_TIMEOUT:
            prox = iniciar_ed ? PREPARACAO : FIM_TIMEOUT;
         default:
            prox = INICIAL;
      endcase
   end

   assign zeraC     = (estado == PREPARACAO);
   assign zeraR     = (estado == PREPARACAO);
   assign registraR = (estado == REGISTRA);
   assign contaC    = (estado == PROXIMO);
   assign acertou   = (estado == FIM_ACERTO);
   assign errou     = (estado == FIM_ERRO) | (estado == FIM_TIMEOUT);
   assign pronto    = acertou | errou;
   assign db_estado = estado;

endmodule

// File: tb/tb_exp4_unidade_controle.sv
// Scoreboard bench for exp4_unidade_controle.
// Build with UNIDADE_CONTROLE_TIMEOUT_EN to exercise the timeout paths.
module tb_exp4_unidade_controle;

`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
   localparam int TO   = 8;
   localparam int HOLD = 5;
`else
   localparam int TO   = 5000;
   localparam int HOLD = 16;
`endif

   logic       clock = 1'b0;
   logic       reset_n;
   logic       iniciar;
   logic       jogada;
   logic       eq;
   logic       fimc;
   logic       zerac, contac, zerar, registrar;
   logic       pronto, acertou, errou, timeout;
   logic [3:0] db_estado;
   logic [11:0] obs;

   int n_vec = 0;
   int n_err = 0;
   int n_conta = 0;
   int n_reg = 0;
   logic [11:0] sb_q[$];

   exp4_unidade_controle #(.TIMEOUT_CYCLES(TO)) dut (
      .clock(clock),
      .reset_n(reset_n),
      .iniciar(iniciar),
      .jogada(jogada),
      .chavesIgualMemoria(eq),
      .fimC(fimc),
      .zeraC(zerac),
      .contaC(contac),
      .zeraR(zerar),
      .registraR(registrar),
      .pronto(pronto),
      .acertou(acertou),
      .errou(errou),
      .timeout(timeout),
      .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   assign obs = {db_estado, zerac, contac, zerar, registrar,
                 pronto, acertou, errou, timeout};

   always @(negedge clock) begin
      if (contac) n_conta++;
      if (registrar) n_reg++;
   end

   // {code, zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout}
   function automatic logic [11:0] exp_out(input logic [3:0] c);
      logic [7:0] o;
      o = 8'b0;
      case (c)
         4'h1: o = 8'b1010_0000;
         4'h4: o = 8'b0001_0000;
         4'h6: o = 8'b0100_0000;
         4'hA: o = 8'b0000_1100;
         4'hE: o = 8'b0000_1010;
         4'hD: o = 8'b0000_1011;
         default: o = 8'b0;
      endcase
      return {c, o};
   endfunction

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input string tag, input logic ini, input logic jog,
                       input logic e, input logic f, input logic [3:0] c);
      logic [11:0] x;
      iniciar = ini;
      jogada  = jog;
      eq      = e;
      fimc    = f;
      sb_q.push_back(exp_out(c));
      @(negedge clock);
      x = sb_q.pop_front();
      check(tag, {20'b0, obs}, {20'b0, x});
   endtask

   task automatic word(input string tag, input logic e, input logic f,
                       input logic [3:0] c);
      tick({tag, "_esp"}, 1'b0, 1'b1, 1'b0, 1'b0, 4'h4);
      tick({tag, "_reg"}, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5);
      tick({tag, "_cmp"}, 1'b0, 1'b0, e, f, c);
      if (c == 4'h6) tick({tag, "_prx"}, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      reset_n = 1'b0;
      iniciar = 1'b0;
      jogada  = 1'b0;
      eq      = 1'b0;
      fimc    = 1'b0;
      repeat (2) @(negedge clock);
      check("reset", {20'b0, obs}, 32'h0);
      reset_n = 1'b1;
      tick("idle", 0, 0, 0, 0, 4'h0);

      // Full correct round
      base = n_conta;
      tick("start", 1, 0, 0, 0, 4'h1);
      tick("prep", 1, 0, 0, 0, 4'h2);
      for (int w = 0; w < 15; w++) word("ok", 1'b1, 1'b0, 4'h6);
      word("last", 1'b1, 1'b1, 4'hA);
      tick("acerto_hold", 0, 0, 0, 0, 4'hA);
      check("conta_full", n_conta - base, 15);

      // Restart from fim_acerto, then iniciar toggles in espera
      tick("restart", 1, 0, 0, 0, 4'h1);
      tick("restart_esp", 0, 0, 0, 0, 4'h2);
      tick("ini_esp1", 1, 0, 0, 0, 4'h2);
      tick("ini_esp2", 0, 0, 0, 0, 4'h2);
      tick("ini_esp3", 1, 0, 0, 0, 4'h2);
      tick("ini_esp4", 0, 0, 0, 0, 4'h2);

      // Mismatch on third word
      base = n_conta;
      word("m1", 1'b1, 1'b0, 4'h6);
      word("m2", 1'b1, 1'b0, 4'h6);
      word("m3", 1'b0, 1'b1, 4'hE);
      tick("erro_hold", 0, 0, 0, 0, 4'hE);
      check("conta_err", n_conta - base, 2);

      // Held button
      tick("restart2", 1, 0, 0, 0, 4'h1);
      tick("restart2_esp", 0, 0, 0, 0, 4'h2);
      base = n_reg;
      tick("hold_reg", 0, 1, 0, 0, 4'h4);
      tick("hold_cmp", 0, 1, 0, 0, 4'h5);
      tick("hold_prx", 0, 1, 1, 0, 4'h6);
      tick("hold_esp", 0, 1, 0, 0, 4'h2);
      for (int i = 0; i < HOLD; i++) tick("hold_stay", 0, 1, 0, 0, 4'h2);
      tick("hold_rel", 0, 0, 0, 0, 4'h2);
      check("hold_nreg", n_reg - base, 1);

      // Asynchronous reset while in proximo
      word("pre_rst", 1'b1, 1'b0, 4'h6);
      tick("to_reg", 0, 1, 0, 0, 4'h4);
      tick("to_cmp", 0, 0, 0, 0, 4'h5);
      jogada = 1'b0;
      eq = 1'b1;
      @(posedge clock);
      #1;
      check("in_prox", {28'b0, db_estado}, 32'h6);
      #2 reset_n = 1'b0;
      #1 check("rst_async", {20'b0, obs}, 32'h0);
      @(negedge clock);
      check("rst_held", {20'b0, obs}, 32'h0);
      reset_n = 1'b1;
      tick("post_rst", 0, 0, 0, 0, 4'h0);
      tick("post_start", 1, 0, 0, 0, 4'h1);
      tick("post_prep", 0, 0, 0, 0, 4'h2);

`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
      for (int i = 0; i < TO - 1; i++) tick("to_wait", 0, 0, 0, 0, 4'h2);
      tick("to_fire", 0, 0, 0, 0, 4'hD);
      tick("to_hold", 0, 0, 0, 0, 4'hD);
      tick("to_restart", 1, 0, 0, 0, 4'h1);
      tick("to_esp", 0, 0, 0, 0, 4'h2);
      for (int i = 0; i < TO - 1; i++) tick("to_wait2", 0, 0, 0, 0, 4'h2);
      tick("to_edge", 0, 1, 0, 0, 4'h4);
      tick("to_cmp", 0, 0, 0, 0, 4'h5);
      tick("to_prx", 0, 0, 1, 0, 4'h6);
      tick("to_back", 0, 0, 0, 0, 4'h2);
`else
      for (int i = 0; i < 30; i++) tick("no_to", 0, 0, 0, 0, 4'h2);
      word("after_wait", 1'b1, 1'b0, 4'h6);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
